// File: rtl/axi_ram_pkg.sv
// Shared burst/response codes and FSM state types for the AXI burst RAM.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } writeState_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } readState_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat-to-beat address stepping and burst legality check for one AXI engine.
// Given the current beat address and the burst attributes it returns the
// address of the following beat and flags bursts the RAM cannot serve.
module axi_burst_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int STROBE_WIDTH  = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [7:0]               len_i,
  input  logic [2:0]               size_i,
  input  logic [1:0]               burst_i,
  output logic [ADDRESS_WIDTH-1:0] next_addr_o,
  output logic                     error_o
);

  localparam int SIZE_MAX = $clog2(STROBE_WIDTH);

  logic [ADDRESS_WIDTH-1:0] step;
  logic [ADDRESS_WIDTH-1:0] lenPlusOne;
  logic [ADDRESS_WIDTH-1:0] wrapMask;
  logic [ADDRESS_WIDTH-1:0] incrAddr;
  logic                     lenWrappable;

  // Next address: a window larger than the address space truncates to an all-ones mask, i.e. plain modulo wrap.
  always_comb begin
    step         = ADDRESS_WIDTH'(1) << size_i;
    lenPlusOne   = ADDRESS_WIDTH'({1'b0, len_i} + 9'd1);
    wrapMask     = (lenPlusOne << size_i) - ADDRESS_WIDTH'(1);
    incrAddr     = addr_i + step;
    lenWrappable = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    error_o      = (size_i > 3'(SIZE_MAX)) || (burst_i == BURST_RSVD) ||
                   ((burst_i == BURST_WRAP) && !lenWrappable);
    next_addr_o  = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = incrAddr;
      BURST_WRAP: next_addr_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 burst-capable byte-addressed RAM with independent read and write engines.
// Reads are registered: the word for a beat is captured when the previous
// handshake happens, so a same-cycle write to that word returns the old data
// and the beat stays stable however long the master stalls.
module axi_burst_ram
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STROBE_WIDTH-1:0]  wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int LANE_BITS   = $clog2(STROBE_WIDTH);
  localparam int INDEX_WIDTH = ADDRESS_WIDTH - LANE_BITS;
  localparam int DEPTH       = 2 ** INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write engine registers
  writeState_e              wState_q, wState_d;
  logic [ADDRESS_WIDTH-1:0] wAddr_q, wAddr_d;
  logic [7:0]               wLen_q, wLen_d;
  logic [2:0]               wSize_q, wSize_d;
  logic [1:0]               wBurst_q, wBurst_d;
  logic [8:0]               wBeatsLeft_q, wBeatsLeft_d;
  logic                     wLastBad_q, wLastBad_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [ADDRESS_WIDTH-1:0] wNextAddr;
  logic                     wError;
  logic                     wLastBeat;
  logic                     memWrite;

  // Read engine registers
  readState_e               rState_q, rState_d;
  logic [ADDRESS_WIDTH-1:0] rAddr_q, rAddr_d;
  logic [7:0]               rLen_q, rLen_d;
  logic [2:0]               rSize_q, rSize_d;
  logic [1:0]               rBurst_q, rBurst_d;
  logic [8:0]               rBeatsLeft_q, rBeatsLeft_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [ADDRESS_WIDTH-1:0] rNextAddr;
  logic                     rError;
  logic                     rLastBeat;

  axi_burst_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .STROBE_WIDTH (STROBE_WIDTH)
  ) writeAddrGen (
    .addr_i     (wAddr_q),
    .len_i      (wLen_q),
    .size_i     (wSize_q),
    .burst_i    (wBurst_q),
    .next_addr_o(wNextAddr),
    .error_o    (wError)
  );

  axi_burst_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .STROBE_WIDTH (STROBE_WIDTH)
  ) readAddrGen (
    .addr_i     (rAddr_q),
    .len_i      (rLen_q),
    .size_i     (rSize_q),
    .burst_i    (rBurst_q),
    .next_addr_o(rNextAddr),
    .error_o    (rError)
  );

  assign wLastBeat = (wBeatsLeft_q == 9'd1);
  assign rLastBeat = (rBeatsLeft_q == 9'd1);

  assign awready = (wState_q == W_IDLE);
  assign wready  = (wState_q == W_DATA);
  assign bvalid  = (wState_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (rState_q == R_IDLE);
  assign rvalid  = (rState_q == R_DATA);
  assign rlast   = (rState_q == R_DATA) && rLastBeat;
  assign rresp   = ((rState_q == R_DATA) && rError) ? RESP_SLVERR : RESP_OKAY;
  assign rdata   = rdata_q;

  // Write engine next state: capture the burst, count beats, latch the response on the final beat.
  always_comb begin
    wState_d     = wState_q;
    wAddr_d      = wAddr_q;
    wLen_d       = wLen_q;
    wSize_d      = wSize_q;
    wBurst_d     = wBurst_q;
    wBeatsLeft_d = wBeatsLeft_q;
    wLastBad_d   = wLastBad_q;
    bresp_d      = bresp_q;
    memWrite     = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (awvalid) begin
          wState_d     = W_DATA;
          wAddr_d      = awaddr;
          wLen_d       = awlen;
          wSize_d      = awsize;
          wBurst_d     = awburst;
          wBeatsLeft_d = {1'b0, awlen} + 9'd1;
          wLastBad_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          memWrite = !wError;
          if (wlast != wLastBeat) begin
            wLastBad_d = 1'b1;
          end
          if (wLastBeat) begin
            wState_d = W_RESP;
            bresp_d  = (wError || wLastBad_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wAddr_d      = wNextAddr;
            wBeatsLeft_d = wBeatsLeft_q - 9'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Write engine state register; reset abandons any burst without a response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wState_q     <= W_IDLE;
      wAddr_q      <= '0;
      wLen_q       <= '0;
      wSize_q      <= '0;
      wBurst_q     <= '0;
      wBeatsLeft_q <= '0;
      wLastBad_q   <= 1'b0;
      bresp_q      <= RESP_OKAY;
    end else begin
      wState_q     <= wState_d;
      wAddr_q      <= wAddr_d;
      wLen_q       <= wLen_d;
      wSize_q      <= wSize_d;
      wBurst_q     <= wBurst_d;
      wBeatsLeft_q <= wBeatsLeft_d;
      wLastBad_q   <= wLastBad_d;
      bresp_q      <= bresp_d;
    end
  end

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (memWrite && !areset) begin
      for (int lane = 0; lane < STROBE_WIDTH; lane++) begin
        if (wstrb[lane]) begin
          mem[wAddr_q[ADDRESS_WIDTH-1:LANE_BITS]][lane*8 +: 8] <= wdata[lane*8 +: 8];
        end
      end
    end
  end

  // Read engine next state: prefetch the word for the upcoming beat at each handshake.
  always_comb begin
    rState_d     = rState_q;
    rAddr_d      = rAddr_q;
    rLen_d       = rLen_q;
    rSize_d      = rSize_q;
    rBurst_d     = rBurst_q;
    rBeatsLeft_d = rBeatsLeft_q;
    rdata_d      = rdata_q;
    case (rState_q)
      R_IDLE: begin
        if (arvalid) begin
          rState_d     = R_DATA;
          rAddr_d      = araddr;
          rLen_d       = arlen;
          rSize_d      = arsize;
          rBurst_d     = arburst;
          rBeatsLeft_d = {1'b0, arlen} + 9'd1;
          rdata_d      = mem[araddr[ADDRESS_WIDTH-1:LANE_BITS]];
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rLastBeat) begin
            rState_d = R_IDLE;
          end else begin
            rAddr_d      = rNextAddr;
            rBeatsLeft_d = rBeatsLeft_q - 9'd1;
            rdata_d      = mem[rNextAddr[ADDRESS_WIDTH-1:LANE_BITS]];
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Read engine state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rState_q     <= R_IDLE;
      rAddr_q      <= '0;
      rLen_q       <= '0;
      rSize_q      <= '0;
      rBurst_q     <= '0;
      rBeatsLeft_q <= '0;
      rdata_q      <= '0;
    end else begin
      rState_q     <= rState_d;
      rAddr_q      <= rAddr_d;
      rLen_q       <= rLen_d;
      rSize_q      <= rSize_d;
      rBurst_q     <= rBurst_d;
      rBeatsLeft_q <= rBeatsLeft_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Self-checking bench for axi_burst_ram (32-bit data, 256-byte memory).
// A byte-array model tracks memory contents; beat addresses are computed
// arithmetically from the burst rules.
module tb_axi_burst_ram;

  logic        aclk, areset;
  logic [7:0]  awaddr, awlen, araddr, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [256];
  logic [31:0] beatData [256];
  logic [3:0]  beatStrb [256];
  logic [31:0] rdData [256];
  logic [1:0]  rdResp [256];
  logic        rdLast [256];
  int          rdCount, rdCycles, rdUnstable;
  logic        rdTimedOut, rdFirstValid, rdEndValid;
  logic [1:0]  wrResp;
  logic        wrTimedOut;

  axi_burst_ram dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Byte address of beat i, straight from the FIXED/INCR/WRAP rules.
  function automatic logic [7:0] beatAddr(input logic [7:0] start, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst, input int i);
    int s, step, win, base;
    s = int'(start);
    step = 1 << size;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      win  = (int'(len) + 1) * step;
      base = (s / win) * win;
      return 8'((base + ((s - base) + i * step) % win) % 256);
    end
    return 8'((s + i * step) % 256);
  endfunction

  function automatic logic burstIllegal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [31:0] modelWord(input logic [7:0] addr);
    int b;
    b = int'(addr) & 252;
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic applyWriteToModel(input logic [7:0] start, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    int b;
    if (!burstIllegal(len, size, burst)) begin
      for (int i = 0; i <= int'(len); i++) begin
        b = int'(beatAddr(start, len, size, burst, i)) & 252;
        for (int l = 0; l < 4; l++)
          if (beatStrb[i][l]) model[b+l] = beatData[i][l*8 +: 8];
      end
    end
  endtask

  // Drives one write burst from beatData/beatStrb; badLastBeat inverts wlast on that beat.
  task automatic writeBurst(input logic [7:0] start, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int badLastBeat);
    int beats, cnt;
    beats = int'(len) + 1;
    wrTimedOut = 1'b0;
    wrResp = 2'bxx;
    awaddr = start; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (awready !== 1'b1 && cnt < 200) begin @(posedge aclk); #1; cnt++; end
    if (awready !== 1'b1) begin wrTimedOut = 1'b1; awvalid = 1'b0; return; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      wdata = beatData[i]; wstrb = beatStrb[i];
      wlast = (i == beats - 1) ^ (i == badLastBeat);
      wvalid = 1'b1;
      cnt = 0;
      while (wready !== 1'b1 && cnt < 200) begin @(posedge aclk); #1; cnt++; end
      if (wready !== 1'b1) begin wrTimedOut = 1'b1; wvalid = 1'b0; return; end
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    end
    cnt = 0;
    while (bvalid !== 1'b1 && cnt < 200) begin @(posedge aclk); #1; cnt++; end
    if (bvalid !== 1'b1) begin wrTimedOut = 1'b1; return; end
    wrResp = bresp;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // Drives one read burst; mode 0: rready high, 1: random rready, 2: rready from pattern bits.
  task automatic readBurst(input logic [7:0] start, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, input logic [15:0] pattern);
    int beats, cnt;
    logic haveHeld, heldLast;
    logic [31:0] heldData;
    logic [1:0] heldResp;
    beats = int'(len) + 1;
    rdCount = 0; rdCycles = 0; rdUnstable = 0; rdTimedOut = 1'b0; rdFirstValid = 1'b0;
    haveHeld = 1'b0; heldData = '0; heldResp = '0; heldLast = 1'b0;
    araddr = start; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (arready !== 1'b1 && cnt < 200) begin @(posedge aclk); #1; cnt++; end
    if (arready !== 1'b1) begin rdTimedOut = 1'b1; arvalid = 1'b0; return; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rdFirstValid = rvalid;
    while (rdCount < beats && rdCycles < 2000) begin
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) rready = 1'($urandom_range(0, 1));
      else rready = (rdCycles < 16) ? pattern[rdCycles] : 1'b1;
      if (rvalid === 1'b1) begin
        if (haveHeld && (rdata !== heldData || rresp !== heldResp || rlast !== heldLast)) rdUnstable++;
        if (rready) begin
          rdData[rdCount] = rdata; rdResp[rdCount] = rresp; rdLast[rdCount] = rlast;
          rdCount++;
          haveHeld = 1'b0;
        end else begin
          heldData = rdata; heldResp = rresp; heldLast = rlast; haveHeld = 1'b1;
        end
      end else if (haveHeld) begin
        rdUnstable++;
      end
      @(posedge aclk); #1;
      rdCycles++;
    end
    rready = 1'b0;
    rdEndValid = rvalid;
    if (rdCount < beats) rdTimedOut = 1'b1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("[TB] FAIL reset_awready: got %b expected 1", awready); end
    checks++; if (arready !== 1'b1) begin errors++; $display("[TB] FAIL reset_arready: got %b expected 1", arready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wready: got %b expected 0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid: got %b expected 0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_rlast: got %b expected 0", rlast); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("[TB] FAIL reset_bresp: got %b expected 00", bresp); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("[TB] FAIL reset_rresp: got %b expected 00", rresp); end
    areset = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 64; i++) begin beatData[i] = $urandom; beatStrb[i] = 4'hF; end
    writeBurst(8'h00, 8'd63, 3'd2, 2'b01, -1);
    checks++; if (wrTimedOut !== 1'b0 || wrResp !== 2'b00) begin errors++; $display("[TB] FAIL fill_bresp: got %b timeout %b expected 00", wrResp, wrTimedOut); end
    applyWriteToModel(8'h00, 8'd63, 3'd2, 2'b01);
    readBurst(8'h00, 8'd63, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL fill_read_timeout: got %0d beats expected 64", rdCount); end
    for (int i = 0; i < rdCount; i++) begin
      checks++;
      if (rdData[i] !== modelWord(8'(i * 4))) begin errors++; $display("[TB] FAIL fill_data[%0d]: got %h expected %h", i, rdData[i], modelWord(8'(i * 4))); end
    end
  endtask

  task automatic test_incr_readback;
    for (int i = 0; i < 4; i++) begin beatData[i] = 32'hA0 + i; beatStrb[i] = 4'hF; end
    writeBurst(8'h10, 8'd3, 3'd2, 2'b01, -1);
    checks++; if (wrTimedOut !== 1'b0 || wrResp !== 2'b00) begin errors++; $display("[TB] FAIL incr_bresp: got %b timeout %b expected 00", wrResp, wrTimedOut); end
    applyWriteToModel(8'h10, 8'd3, 3'd2, 2'b01);
    readBurst(8'h10, 8'd3, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdFirstValid !== 1'b1) begin errors++; $display("[TB] FAIL incr_first_rvalid: got %b expected 1", rdFirstValid); end
    checks++; if (rdTimedOut !== 1'b0 || rdCycles != 4) begin errors++; $display("[TB] FAIL incr_cycles: got %0d expected 4", rdCycles); end
    checks++; if (rdEndValid !== 1'b0) begin errors++; $display("[TB] FAIL incr_end_rvalid: got %b expected 0", rdEndValid); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdData[i] !== 32'hA0 + i || rdResp[i] !== 2'b00 || rdLast[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL incr_beat[%0d]: got %h/%b/%b expected %h/00/%b", i, rdData[i], rdResp[i], rdLast[i], 32'hA0 + i, i == 3);
      end
    end
  endtask

  task automatic test_wrap_read;
    logic [7:0] addrs [4];
    addrs[0] = 8'h18; addrs[1] = 8'h1C; addrs[2] = 8'h10; addrs[3] = 8'h14;
    readBurst(8'h18, 8'd3, 3'd2, 2'b10, 0, 16'h0);
    checks++; if (rdTimedOut !== 1'b0) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d beats expected 4", rdCount); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdData[i] !== modelWord(addrs[i]) || rdResp[i] !== 2'b00 || rdLast[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL wrap_beat[%0d]: got %h/%b/%b expected %h/00/%b", i, rdData[i], rdResp[i], rdLast[i], modelWord(addrs[i]), i == 3);
      end
    end
  endtask

  task automatic test_strobe;
    beatData[0] = 32'hFFFF_FFFF; beatStrb[0] = 4'hF;
    writeBurst(8'h20, 8'd0, 3'd2, 2'b01, -1);
    applyWriteToModel(8'h20, 8'd0, 3'd2, 2'b01);
    beatData[0] = 32'h1234_5678; beatStrb[0] = 4'b0101;
    writeBurst(8'h20, 8'd0, 3'd2, 2'b01, -1);
    checks++; if (wrResp !== 2'b00) begin errors++; $display("[TB] FAIL strobe_bresp: got %b expected 00", wrResp); end
    applyWriteToModel(8'h20, 8'd0, 3'd2, 2'b01);
    readBurst(8'h20, 8'd0, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdData[0] !== 32'hFF34_FF78 || rdLast[0] !== 1'b1) begin errors++; $display("[TB] FAIL strobe_data: got %h last %b expected ff34ff78 last 1", rdData[0], rdLast[0]); end
  endtask

  task automatic test_size_error;
    logic [31:0] oldWord;
    readBurst(8'h00, 8'd1, 3'd3, 2'b01, 0, 16'h0);
    checks++; if (rdTimedOut !== 1'b0 || rdCount != 2) begin errors++; $display("[TB] FAIL size_err_beats: got %0d expected 2", rdCount); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdResp[i] !== 2'b10 || rdLast[i] !== (i == 1)) begin errors++; $display("[TB] FAIL size_err_beat[%0d]: got %b/%b expected 10/%b", i, rdResp[i], rdLast[i], i == 1); end
    end
    oldWord = modelWord(8'h30);
    beatData[0] = ~oldWord; beatStrb[0] = 4'hF; beatData[1] = ~oldWord; beatStrb[1] = 4'hF;
    writeBurst(8'h30, 8'd1, 3'd2, 2'b11, -1);
    checks++; if (wrResp !== 2'b10) begin errors++; $display("[TB] FAIL burst_err_bresp: got %b expected 10", wrResp); end
    readBurst(8'h30, 8'd0, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdData[0] !== oldWord) begin errors++; $display("[TB] FAIL burst_err_nowrite: got %h expected %h", rdData[0], oldWord); end
  endtask

  task automatic test_wlast_mismatch;
    beatData[0] = $urandom; beatStrb[0] = 4'hF; beatData[1] = $urandom; beatStrb[1] = 4'hF;
    writeBurst(8'h38, 8'd1, 3'd2, 2'b01, 1);
    checks++; if (wrResp !== 2'b10) begin errors++; $display("[TB] FAIL wlast_bresp: got %b expected 10", wrResp); end
    applyWriteToModel(8'h38, 8'd1, 3'd2, 2'b01);
    readBurst(8'h38, 8'd1, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdData[1] !== modelWord(8'h3C)) begin errors++; $display("[TB] FAIL wlast_data_written: got %h expected %h", rdData[1], modelWord(8'h3C)); end
  endtask

  task automatic test_stall;
    readBurst(8'h10, 8'd3, 3'd2, 2'b01, 2, 16'hFFF9);
    checks++; if (rdUnstable != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", rdUnstable); end
    checks++; if (rdTimedOut !== 1'b0 || rdCycles != 6) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected 6", rdCycles); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdData[i] !== modelWord(8'(8'h10 + i * 4)) || rdLast[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL stall_beat[%0d]: got %h/%b expected %h/%b", i, rdData[i], rdLast[i], modelWord(8'(8'h10 + i * 4)), i == 3);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    araddr = 8'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== modelWord(8'h44)) begin errors++; $display("[TB] FAIL rst_beat2: got %h valid %b expected %h", rdata, rvalid, modelWord(8'h44)); end
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; rready = 1'b0;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle: got rvalid %b arready %b expected 0 1", rvalid, arready); end
    readBurst(8'h40, 8'd7, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdTimedOut !== 1'b0 || rdCycles != 8) begin errors++; $display("[TB] FAIL rst_after_cycles: got %0d expected 8", rdCycles); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdData[i] !== modelWord(8'(8'h40 + i * 4)) || rdLast[i] !== (i == 7)) begin
        errors++; $display("[TB] FAIL rst_after_beat[%0d]: got %h/%b expected %h/%b", i, rdData[i], rdLast[i], modelWord(8'(8'h40 + i * 4)), i == 7);
      end
    end
  endtask

  task automatic test_same_word_collision;
    logic [31:0] oldWord, newWord;
    oldWord = modelWord(8'h50);
    newWord = ~oldWord;
    awaddr = 8'h50; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wdata = newWord; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 8'h50; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== oldWord) begin errors++; $display("[TB] FAIL collision_old_data: got %h valid %b expected %h", rdata, rvalid, oldWord); end
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("[TB] FAIL collision_bresp: got %b valid %b expected 00", bresp, bvalid); end
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    model[8'h50] = newWord[7:0]; model[8'h51] = newWord[15:8]; model[8'h52] = newWord[23:16]; model[8'h53] = newWord[31:24];
    readBurst(8'h50, 8'd0, 3'd2, 2'b01, 0, 16'h0);
    checks++; if (rdData[0] !== newWord) begin errors++; $display("[TB] FAIL collision_new_data: got %h expected %h", rdData[0], newWord); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin beatData[i] = $urandom; beatStrb[i] = 4'($urandom_range(0, 15)); end
    fork
      writeBurst(8'h80, 8'd7, 3'd2, 2'b01, -1);
      readBurst(8'hC0, 8'd7, 3'd2, 2'b01, 1, 16'h0);
    join
    checks++; if (wrTimedOut !== 1'b0 || wrResp !== 2'b00) begin errors++; $display("[TB] FAIL concurrent_bresp: got %b expected 00", wrResp); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdData[i] !== modelWord(8'(8'hC0 + i * 4))) begin errors++; $display("[TB] FAIL concurrent_read[%0d]: got %h expected %h", i, rdData[i], modelWord(8'(8'hC0 + i * 4))); end
    end
    applyWriteToModel(8'h80, 8'd7, 3'd2, 2'b01);
    for (int k = 0; k < 2; k++) begin
      readBurst(8'h80, 8'd7, 3'd2, 2'b01, 0, 16'h0);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rdData[i] !== modelWord(8'(8'h80 + i * 4))) begin errors++; $display("[TB] FAIL b2b_read%0d[%0d]: got %h expected %h", k, i, rdData[i], modelWord(8'(8'h80 + i * 4))); end
      end
    end
  endtask

  task automatic test_random_bursts;
    logic [7:0] start, len;
    logic [2:0] size;
    logic [1:0] burst, expResp;
    int r, beats;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      burst = (r < 1) ? 2'b11 : (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
      size  = 3'($urandom_range(0, 3));
      start = 8'($urandom_range(0, 255));
      if (burst == 2'b10) begin
        r = $urandom_range(0, 4);
        len = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : (r == 3) ? 8'd15 : 8'd2;
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      beats = int'(len) + 1;
      expResp = burstIllegal(len, size, burst) ? 2'b10 : 2'b00;
      for (int i = 0; i < beats; i++) begin beatData[i] = $urandom; beatStrb[i] = 4'($urandom_range(0, 15)); end
      writeBurst(start, len, size, burst, -1);
      checks++;
      if (wrTimedOut !== 1'b0 || wrResp !== expResp) begin errors++; $display("[TB] FAIL rand%0d_bresp: got %b expected %b", n, wrResp, expResp); end
      applyWriteToModel(start, len, size, burst);
      readBurst(start, len, size, burst, 1, 16'h0);
      checks++;
      if (rdTimedOut !== 1'b0 || rdUnstable != 0) begin errors++; $display("[TB] FAIL rand%0d_read: got %0d beats %0d changes expected %0d 0", n, rdCount, rdUnstable, beats); end
      for (int i = 0; i < rdCount; i++) begin
        checks++;
        if (rdResp[i] !== expResp || rdLast[i] !== (i == beats - 1) ||
            (expResp == 2'b00 && rdData[i] !== modelWord(beatAddr(start, len, size, burst, i)))) begin
          errors++;
          $display("[TB] FAIL rand%0d_beat[%0d]: got %h/%b/%b expected %h/%b/%b", n, i, rdData[i], rdResp[i], rdLast[i],
                   modelWord(beatAddr(start, len, size, burst, i)), expResp, i == beats - 1);
        end
      end
    end
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    @(posedge aclk); #1;
    test_reset;
    test_fill;
    test_incr_readback;
    test_wrap_read;
    test_strobe;
    test_size_error;
    test_wlast_mismatch;
    test_stall;
    test_reset_mid_burst;
    test_same_word_collision;
    test_back_to_back;
    test_random_bursts;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
